// File: rtl/hpu_pkg.sv
// Shared types for the hypervector bundling path: per-lane step encoding,
// bundle FSM states and tie-break modes.
package hpu_pkg;

   typedef logic signed [1:0] step_t;

   localparam step_t STEP_POS  = 2'sb01;
   localparam step_t STEP_NEG  = 2'sb11;
   localparam step_t STEP_ZERO = 2'sb00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } bundle_state_t;

   localparam int unsigned TIE_VEC  = 0;
   localparam int unsigned TIE_ZERO = 1;
   localparam int unsigned TIE_ONE  = 2;

endpackage : hpu_pkg

// File: rtl/bundle_lane.sv
// One hypervector lane: step register, saturating signed counter,
// majority threshold with tie resolution, and a clip indicator.
module bundle_lane
   import hpu_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TIE_MODE = TIE_VEC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  logic in_bit_i,
   input  logic store_i,
   input  logic tie_i,
   output logic maj_c_o,
   output logic clip_c_o
);

   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << (CNT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] CNT_MIN = SUM_W'(-(1 << (CNT_W - 1)));

   step_t                     step_q, step_d;
   logic signed [CNT_W-1:0]   cnt_q, cnt_d;
   logic signed [SUM_W-1:0]   sum_c;

   // Step encode, saturating add, and threshold of the value about to be stored
   always_comb begin
      step_d   = STEP_ZERO;
      clip_c_o = 1'b0;
      maj_c_o  = 1'b0;
      if (load_i && store_i) begin
         step_d = in_bit_i ? STEP_NEG : STEP_POS;
      end

      sum_c = SUM_W'(cnt_q) + SUM_W'(step_q);
      if (sum_c > CNT_MAX) begin
         cnt_d    = CNT_MAX[CNT_W-1:0];
         clip_c_o = 1'b1;
      end else if (sum_c < CNT_MIN) begin
         cnt_d    = CNT_MIN[CNT_W-1:0];
         clip_c_o = 1'b1;
      end else begin
         cnt_d = sum_c[CNT_W-1:0];
      end

      if (cnt_d == '0) begin
         if (TIE_MODE == TIE_ZERO) begin
            maj_c_o = 1'b0;
         end else if (TIE_MODE == TIE_ONE) begin
            maj_c_o = 1'b1;
         end else begin
            maj_c_o = tie_i;
         end
      end else begin
         maj_c_o = cnt_d[CNT_W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         step_q <= STEP_ZERO;
         cnt_q  <= '0;
      end else begin
         step_q <= step_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule : bundle_lane

// File: rtl/bundle_accumulator.sv
// DIM-lane saturating bundle accumulator; thresholds to a majority
// hypervector on finalize and emits it over a valid/ready handshake.
module bundle_accumulator
   import hpu_pkg::*;
#(
   parameter int unsigned DIM      = 32,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TIE_MODE = TIE_VEC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIM-1:0]   in_vec,
   input  logic [DIM-1:0]   in_store,
   input  logic [DIM-1:0]   tie_vec,
   input  logic             fin_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIM-1:0]   out_vec,
   output logic [CNT_W-1:0] out_count,
   output logic             sat_flag
);

   bundle_state_t    state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [DIM-1:0]   out_vec_q, out_vec_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;

   logic             accept_c;
   logic             hs_c;
   logic             lane_clr_c;
   logic [DIM-1:0]   maj_c;
   logic [DIM-1:0]   clip_c;

   assign accept_c   = in_valid & in_ready_q & ~clear;
   assign hs_c       = out_valid_q & out_ready;
   assign lane_clr_c = clear | hs_c;

   for (genvar g = 0; g < int'(DIM); g++) begin : g_lane
      bundle_lane #(
         .CNT_W    (CNT_W),
         .TIE_MODE (TIE_MODE)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr_i    (lane_clr_c),
         .load_i   (accept_c),
         .in_bit_i (in_vec[g]),
         .store_i  (in_store[g]),
         .tie_i    (tie_vec[g]),
         .maj_c_o  (maj_c[g]),
         .clip_c_o (clip_c[g])
      );
   end

   // Next-state and registered-output logic; clear overrides everything
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_vec_d   = out_vec_q;
      count_d     = count_q;
      sat_d       = sat_q | (|clip_c);

      unique case (state_q)
         IDLE: begin
            if (fin_req)       state_d = DRAIN;
            else if (accept_c) state_d = ACCUM;
         end
         ACCUM: begin
            if (fin_req) state_d = DRAIN;
         end
         DRAIN: begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
            out_vec_d   = maj_c;
         end
         EMIT: begin
            if (hs_c) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept_c && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end

      if (lane_clr_c) begin
         count_d = '0;
         sat_d   = 1'b0;
      end
      if (clear) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end

      in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         count_q     <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
         count_q     <= count_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_count = count_q;
   assign sat_flag  = sat_q;

endmodule : bundle_accumulator

// File: tb/tb_bundle_accumulator.sv
// Directed bench for bundle_accumulator (DIM=8, CNT_W=4); a second instance
// with forced-one ties shares the stimulus.
module tb_bundle_accumulator;

   localparam int unsigned DIM   = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n, clear, in_valid, fin_req, out_ready;
   logic [DIM-1:0]   in_vec, in_store, tie_vec;
   logic             in_ready, out_valid, sat_flag;
   logic [DIM-1:0]   out_vec;
   logic [CNT_W-1:0] out_count;
   logic             in_ready2, out_valid2, sat_flag2;
   logic [DIM-1:0]   out_vec2;
   logic [CNT_W-1:0] out_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bundle_accumulator #(.DIM(DIM), .CNT_W(CNT_W), .TIE_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_vec(in_vec), .in_store(in_store),
      .tie_vec(tie_vec), .fin_req(fin_req), .out_valid(out_valid),
      .out_ready(out_ready), .out_vec(out_vec), .out_count(out_count),
      .sat_flag(sat_flag)
   );

   bundle_accumulator #(.DIM(DIM), .CNT_W(CNT_W), .TIE_MODE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready2), .in_vec(in_vec), .in_store(in_store),
      .tie_vec(tie_vec), .fin_req(fin_req), .out_valid(out_valid2),
      .out_ready(out_ready), .out_vec(out_vec2), .out_count(out_count2),
      .sat_flag(sat_flag2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DIM-1:0] v, input logic [DIM-1:0] s, input int n);
      in_valid = 1'b1;
      in_vec   = v;
      in_store = s;
      repeat (n) tick();
      in_valid = 1'b0;
   endtask

   // fin_req for one cycle, then DRAIN, then EMIT
   task automatic finalize(input string tag);
      fin_req = 1'b1;
      tick();
      fin_req = 1'b0;
      chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
      tick();
      chk({tag, "_emit_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_emit_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hs_count"}, 32'(out_count), 32'd0);
      chk({tag, "_hs_sat"}, 32'(sat_flag), 32'd0);
      chk({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; fin_req = 1'b0; out_ready = 1'b0;
      in_vec = '0; in_store = '0; tie_vec = '0;
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_sat", 32'(sat_flag), 32'd0);
      chk("rst_vec", 32'(out_vec), 32'd0);
      rst_n = 1'b1;
      tick();

      // Lanes 0-3 see -1 three times, lanes 4-7 see +1 three times
      send(8'h0F, 8'hFF, 3);
      chk("t1_count_pre", 32'(out_count), 32'd3);
      finalize("t1");
      chk("t1_vec", 32'(out_vec), 32'h0F);
      chk("t1_count", 32'(out_count), 32'd3);
      chk("t1_sat", 32'(sat_flag), 32'd0);
      handshake("t1");

      // +1 and -1 cancel: every lane ties
      send(8'hFF, 8'hFF, 1);
      send(8'h00, 8'hFF, 1);
      tie_vec = 8'hA5;
      finalize("t2");
      chk("t2_vec_tievec", 32'(out_vec), 32'hA5);
      chk("t2_vec_force1", 32'(out_vec2), 32'hFF);
      chk("t2_count", 32'(out_count), 32'd2);
      handshake("t2");

      // Only lane 0 stored (+5); other lanes stay at zero
      tie_vec = 8'h00;
      send(8'hFE, 8'h01, 5);
      finalize("t3");
      chk("t3_vec", 32'(out_vec), 32'h00);
      chk("t3_vec_force1", 32'(out_vec2), 32'hFE);
      chk("t3_count", 32'(out_count), 32'd5);
      // Stall in EMIT with in_valid high: nothing moves
      in_valid = 1'b1; in_vec = 8'hFF; in_store = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_hold_vec", 32'(out_vec), 32'h00);
         chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
         chk("t3_hold_count", 32'(out_count), 32'd5);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t3_rst_valid", 32'(out_valid), 32'd0);
      chk("t3_rst_count", 32'(out_count), 32'd0);
      chk("t3_rst_in_ready", 32'(in_ready), 32'd1);

      // Nine -1 steps clamp the 4-bit counters at -8
      send(8'hFF, 8'hFF, 9);
      finalize("t4");
      chk("t4_vec", 32'(out_vec), 32'hFF);
      chk("t4_sat", 32'(sat_flag), 32'd1);
      chk("t4_count", 32'(out_count), 32'd9);
      handshake("t4");

      // Accept coinciding with fin_req is included
      in_valid = 1'b1; in_vec = 8'h80; in_store = 8'hFF;
      tick();
      fin_req = 1'b1;
      tick();
      in_valid = 1'b0; fin_req = 1'b0;
      tick();
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_count", 32'(out_count), 32'd2);
      chk("t5_vec", 32'(out_vec), 32'h80);
      handshake("t5");

      // clear drops a coincident input
      clear = 1'b1; in_valid = 1'b1; in_vec = 8'hFF; in_store = 8'hFF;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      tick();
      chk("t6_clear_count", 32'(out_count), 32'd0);

      // Empty bundle: pure tie result, count 0
      tie_vec = 8'h00;
      finalize("t6");
      chk("t6_vec", 32'(out_vec), 32'h00);
      chk("t6_vec_force1", 32'(out_vec2), 32'hFF);
      chk("t6_count", 32'(out_count), 32'd0);

      // clear in EMIT drops out_valid
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t7_clear_valid", 32'(out_valid), 32'd0);
      chk("t7_clear_in_ready", 32'(in_ready), 32'd1);
      chk("t7_vec_kept", 32'(out_vec), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bundle_accumulator
